// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO for ALU {Result, Overflow, OpSel} triples with a saturating overflow counter.
// Optional macro ALU_RESULT_FIFO_DROP_OVF_EN: accept but do not store overflowed results.
module alu_result_fifo #(
  parameter int DATA_W  = 4,
  parameter int OPSEL_W = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DATA_W-1:0]        InResult,
  input  logic                     InOverflow,
  input  logic [OPSEL_W-1:0]       InOpSel,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_W-1:0]        OutResult,
  output logic                     OutOverflow,
  output logic [OPSEL_W-1:0]       OutOpSel,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty,
  output logic [CNT_W-1:0]         OvfCount
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic [DATA_W-1:0]  mem_result_q [DEPTH];
  logic               mem_ovf_q    [DEPTH];
  logic [OPSEL_W-1:0] mem_opsel_q  [DEPTH];
  logic [PTR_W-1:0]   count;
  logic               push;
  logic               pop;
  logic               store;

  // Extra pointer MSB tells full from empty when the indices coincide.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign Count    = count;
  assign Full     = (count == PTR_W'(DEPTH));
  assign Empty    = (count == '0);
  assign InReady  = !Full;
  assign OutValid = !Empty;
  assign OvfCount = ovf_cnt_q;

  assign push = InValid && !Full && !Flush;
  assign pop  = !Empty && OutReady && !Flush;

`ifdef ALU_RESULT_FIFO_DROP_OVF_EN
  assign store = push && !InOverflow;
`else
  assign store = push;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_cnt_d = ovf_cnt_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && InOverflow && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage is cleared on reset so the fall-through outputs never show stale data.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mem_result_q[gi] <= '0;
        mem_ovf_q[gi]    <= 1'b0;
        mem_opsel_q[gi]  <= '0;
      end else if (store && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
        mem_result_q[gi] <= InResult;
        mem_ovf_q[gi]    <= InOverflow;
        mem_opsel_q[gi]  <= InOpSel;
      end
    end
  end

  assign OutResult   = mem_result_q[rd_ptr_q[AW-1:0]];
  assign OutOverflow = mem_ovf_q[rd_ptr_q[AW-1:0]];
  assign OutOpSel    = mem_opsel_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: the driver keeps a queue model of the FIFO contents,
// a negedge monitor compares status and pops/compares head data on every transfer.
module tb_alu_result_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Flush = 1'b0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [3:0] InResult = '0;
  logic       InOverflow = 1'b0;
  logic [1:0] InOpSel = '0;
  logic       OutValid;
  logic       OutReady = 1'b0;
  logic [3:0] OutResult;
  logic       OutOverflow;
  logic [1:0] OutOpSel;
  logic [2:0] Count;
  logic       Full;
  logic       Empty;
  logic [7:0] OvfCount;

  alu_result_fifo dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .InResult(InResult),
    .InOverflow(InOverflow), .InOpSel(InOpSel),
    .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
    .OutOverflow(OutOverflow), .OutOpSel(OutOpSel),
    .Count(Count), .Full(Full), .Empty(Empty), .OvfCount(OvfCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic       ovf;
    logic [1:0] op;
  } item_t;

  item_t exp_q[$];
  int    ovf_model = 0;
  int    cur_cnt = 0;
  int    cur_ovf = 0;
  bit    chk_en = 0;
  bit    chk_zero = 0;
  bit    prev_rst = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model is advanced to the state after the coming edge.
  task automatic cycle(input bit rst, input bit fl, input bit iv, input int r,
                       input bit ov, input int op, input bit ordy);
    @(posedge clk);
    #1;
    rst_n      = rst;
    Flush      = fl;
    InValid    = iv;
    InResult   = 4'(r);
    InOverflow = ov;
    InOpSel    = 2'(op);
    OutReady   = ordy;
    cur_cnt    = exp_q.size();
    cur_ovf    = ovf_model;
    chk_zero   = prev_rst;
    if (!rst) begin
      exp_q.delete();
      ovf_model = 0;
    end else if (fl) begin
      exp_q.delete();
    end else if (iv && cur_cnt < DEPTH) begin
      if (ov && ovf_model < 255) ovf_model++;
`ifdef ALU_RESULT_FIFO_DROP_OVF_EN
      if (!ov) exp_q.push_back('{res: 4'(r), ovf: ov, op: 2'(op)});
`else
      exp_q.push_back('{res: 4'(r), ovf: ov, op: 2'(op)});
`endif
    end
    chk_en   = prev_rst || chk_en;
    prev_rst = !rst;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(Count), cur_cnt);
      chk("empty", int'(Empty), int'(cur_cnt == 0));
      chk("full", int'(Full), int'(cur_cnt == DEPTH));
      chk("in_ready", int'(InReady), int'(cur_cnt < DEPTH));
      chk("out_valid", int'(OutValid), int'(cur_cnt > 0));
      chk("ovf_count", int'(OvfCount), cur_ovf);
      if (chk_zero) begin
        chk("rst_out_result", int'(OutResult), 0);
        chk("rst_out_overflow", int'(OutOverflow), 0);
        chk("rst_out_opsel", int'(OutOpSel), 0);
      end
      if (rst_n && !Flush && cur_cnt > 0 && OutReady) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          item_t h;
          h = exp_q.pop_front();
          chk("out_result", int'(OutResult), int'(h.res));
          chk("out_overflow", int'(OutOverflow), int'(h.ovf));
          chk("out_opsel", int'(OutOpSel), int'(h.op));
        end
      end
    end
  end

  initial begin
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    // Single push then pop.
    cycle(1, 0, 1, 8, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    // Fill past full with the consumer stalled, then drain.
    cycle(1, 0, 1, 8, 0, 1, 0);
    cycle(1, 0, 1, 0, 1, 2, 0);
    cycle(1, 0, 1, 5, 0, 3, 0);
    cycle(1, 0, 1, 15, 0, 0, 0);
    cycle(1, 0, 1, 9, 0, 1, 0);
    cycle(1, 0, 1, 9, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0, 1);
    // Streaming push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, i, 0, i % 4, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    // Overflow counter saturation.
    for (int i = 0; i < 300; i++) cycle(1, 0, 1, i, 1, i % 4, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    // Flush with three entries and an incoming overflowed item.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, i + 3, 0, i, 0);
    cycle(1, 1, 1, 7, 1, 2, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    // Reset mid-transfer with two entries held.
    cycle(1, 0, 1, 6, 1, 1, 0);
    cycle(1, 0, 1, 10, 0, 2, 0);
    cycle(0, 0, 1, 11, 1, 3, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 1, 0, 0);
    cycle(1, 0, 1, 8, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle(1, ($urandom_range(0, 29) == 0), $urandom_range(0, 1),
            $urandom_range(0, 15), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 3), ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 4-bit ArithmeticUnit.
- Captures each {Result, Overflow, OpSel} triple the ALU produces into a small FIFO with a valid/ready handshake on both sides.
- Lets the producer and the consumer (result checker/display) run decoupled.
- Also keeps a saturating count of accepted overflow results.

Parameters:
- DATA_W, 4, width of Result.
- OPSEL_W, 2, width of OpSel tag.
- DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, 8, width of OvfCount.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- Flush  input  1  synchronous clear of FIFO contents.
- InValid  input  1  producer has a result this cycle.
- InReady  output  1  FIFO can accept; equals !Full.
- InResult  input  DATA_W  ALU Result.
- InOverflow  input  1  ALU Overflow.
- InOpSel  input  OPSEL_W  operation that produced the result.
- OutValid  output  1  head entry available; equals !Empty.
- OutReady  input  1  consumer takes head entry.
- OutResult  output  DATA_W  head Result.
- OutOverflow  output  1  head Overflow.
- OutOpSel  output  OPSEL_W  head OpSel.
- Count  output  log2(DEPTH)+1  entries held, 0..DEPTH.
- Full  output  1  Count==DEPTH.
- Empty  output  1  Count==0.
- OvfCount  output  CNT_W  accepted entries with Overflow=1, saturating.

Behaviour:
- Reset: synchronous, active-low; rst_n=0 sampled at a rising edge applies it.
  - Read/write pointers and Count are cleared to 0.
  - OvfCount is cleared to 0.
  - After reset: Empty=1, Full=0, InReady=1, OutValid=0.
  - OutResult, OutOverflow and OutOpSel are 0; storage is cleared, so they carry no stale data.
  - Reset mid-transfer discards everything; no push or pop takes effect in that cycle.
- Push: occurs when InValid && InReady at an edge. The triple is written at wr_ptr, wr_ptr increments modulo DEPTH, and Count increments.
- Pop: occurs when OutValid && OutReady at an edge. rd_ptr increments modulo DEPTH and Count decrements.
- First-word fall-through: out data is driven combinationally from the entry at rd_ptr.
  - An entry pushed at edge N is visible with OutValid=1 in the cycle after edge N (latency 1).
- Simultaneous push and pop, not full and not empty: both happen, Count is unchanged, and ordering is preserved.
- Full: InReady=0, so no push occurs even if a pop happens the same cycle. The producer must hold its data.
- Empty: OutValid=0 and OutReady is ignored. A push into an empty FIFO does not bypass to the output in the same cycle.
- Pointers use log2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap-around.
- Flush (rst_n=1, Flush=1):
  - Pointers and Count go to 0 at the edge.
  - Flush overrides push and pop in that cycle; the incoming item is dropped.
  - OvfCount is not cleared.
- OvfCount:
  - Increments by 1 on each push whose InOverflow=1.
  - Holds at 2^CNT_W-1 once saturated.
  - Unaffected by pops.
- Producer and consumer must not change data while valid is high and ready is low. The block does not check this.
- No combinational path from InValid to InReady, or from OutReady to OutValid.

Optional Feature:
- Macro: ALU_RESULT_FIFO_DROP_OVF_EN.
- Defined:
  - Pushes with InOverflow=1 are accepted: InReady behaves as normal and OvfCount increments.
  - They are not stored: pointers and Count are unchanged.
  - Only non-overflow results reach the consumer.
- Undefined: all accepted results are stored, as described in Behaviour.

Test Plan:
- Reset then single push {Result=8, Ovf=0, OpSel=00}.
  - Next cycle: OutValid=1, OutResult=8, Count=1.
  - Pop with OutReady=1: Empty=1, OvfCount=0.
- Push 5 items with OutReady=0 and DEPTH=4, data 8, 0/ovf, 5, 15.
  - After 4 pushes: Full=1 and InReady=0.
  - The 5th item is not accepted; Count stays 4.
  - Draining yields 8, 0, 5, 15 in order; OvfCount=1.
- Continuous push/pop with InValid=OutReady=1 for 10 cycles on incrementing data.
  - Count stays 1 after the first cycle.
  - Outputs match inputs delayed one cycle; pointers wrap correctly.
- 300 pushes all with InOverflow=1, popping concurrently: OvfCount saturates at 255 and holds.
- Flush with 3 entries held while InValid=1: Count=0 and Empty=1 next cycle, the incoming item is dropped, OvfCount is unchanged.
- rst_n=0 asserted with 2 entries held and OutReady=1: next cycle Count=0, OvfCount=0, OutValid=0, outputs all 0.
- With ALU_RESULT_FIFO_DROP_OVF_EN defined, push {0, ovf=1} then {8, ovf=0}: Count=1, head=8, OvfCount=1.
